// File: rtl/demux_1to2_reg.sv
// Registered 1-to-2 demultiplexer with per-channel transfer counters.
//
// Routes each accepted source beat to out0 (in_sel=0) or out1 (in_sel=1).
// Each output channel owns a one-entry register slot; a slot that is being
// drained in the same cycle counts as free, so a channel sustains one beat
// per cycle. A stalled channel only blocks beats that select it.
//
// Ports:
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   in_data/in_sel           source beat and destination select
//   in_valid/in_ready        source handshake (in_ready is combinational from
//                            in_sel, out0_ready, out1_ready and rst)
//   outK_data/outK_valid     channel K registered beat
//   outK_ready               channel K sink accepts
//   cnt0/cnt1                delivered-beat counters, wrap modulo 2^CNTW

module demux_1to2_reg #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNTW  = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_sel,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] out0_data,
   output logic             out0_valid,
   input  logic             out0_ready,
   output logic [WIDTH-1:0] out1_data,
   output logic             out1_valid,
   input  logic             out1_ready,
   output logic [CNTW-1:0]  cnt0,
   output logic [CNTW-1:0]  cnt1
);

   logic [WIDTH-1:0] data0_q, data1_q;
   logic             valid0_q, valid1_q;
   logic [CNTW-1:0]  cnt0_q, cnt1_q;

   logic free0, free1;
   logic drain0, drain1;
   logic accept, acc0, acc1;

   // A slot being drained this cycle can take a new beat in the same cycle.
   assign free0  = !valid0_q || out0_ready;
   assign free1  = !valid1_q || out1_ready;
   assign drain0 = valid0_q && out0_ready;
   assign drain1 = valid1_q && out1_ready;

   assign in_ready = !rst && (in_sel ? free1 : free0);
   assign accept   = in_valid && in_ready;
   assign acc0     = accept && !in_sel;
   assign acc1     = accept && in_sel;

   always_ff @(posedge clk) begin
      if (rst) begin
         data0_q  <= '0;
         data1_q  <= '0;
         valid0_q <= 1'b0;
         valid1_q <= 1'b0;
         cnt0_q   <= '0;
         cnt1_q   <= '0;
      end else begin
         // Accept wins over drain: a beat loaded in the drain cycle keeps valid high.
         if (acc0) begin
            data0_q  <= in_data;
            valid0_q <= 1'b1;
         end else if (drain0) begin
            valid0_q <= 1'b0;
         end

         if (acc1) begin
            data1_q  <= in_data;
            valid1_q <= 1'b1;
         end else if (drain1) begin
            valid1_q <= 1'b0;
         end

         if (drain0) cnt0_q <= cnt0_q + 1'b1;
         if (drain1) cnt1_q <= cnt1_q + 1'b1;
      end
   end

   assign out0_data  = data0_q;
   assign out0_valid = valid0_q;
   assign out1_data  = data1_q;
   assign out1_valid = valid1_q;
   assign cnt0       = cnt0_q;
   assign cnt1       = cnt1_q;

endmodule

// File: tb/tb_demux_1to2_reg.sv
// Self-checking bench for demux_1to2_reg: directed scenarios followed by a
// randomized phase, all checked against a queue-based reference model.

module tb_demux_1to2_reg;

   logic        clk;
   logic        rst;
   logic [31:0] in_data;
   logic        in_sel;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] out0_data;
   logic        out0_valid;
   logic        out0_ready;
   logic [31:0] out1_data;
   logic        out1_valid;
   logic        out1_ready;
   logic [15:0] cnt0;
   logic [15:0] cnt1;

   int total = 0;
   int bad   = 0;

   // Reference model: each channel is a FIFO of capacity one, plus the last
   // value loaded (the data register keeps it after draining) and a count.
   logic [31:0] q0[$];
   logic [31:0] q1[$];
   logic [31:0] last0, last1;
   int          mcnt0, mcnt1;

   demux_1to2_reg #(.WIDTH(32), .CNTW(16)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_data    (in_data),
      .in_sel     (in_sel),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .out0_data  (out0_data),
      .out0_valid (out0_valid),
      .out0_ready (out0_ready),
      .out1_data  (out1_data),
      .out1_valid (out1_valid),
      .out1_ready (out1_ready),
      .cnt0       (cnt0),
      .cnt1       (cnt1)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp)
      else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
      end
   endtask

   // One clock cycle. Inputs are already driven (just after the previous edge).
   task automatic tick();
      logic exp_rdy;
      logic acc;
      #3;
      exp_rdy = !rst && (in_sel ? (q1.size() == 0 || out1_ready)
                                : (q0.size() == 0 || out0_ready));
      chk("in_ready", {31'b0, in_ready}, {31'b0, exp_rdy});
      acc = in_valid && exp_rdy;
      if (rst) begin
         q0.delete();
         q1.delete();
         last0 = '0;
         last1 = '0;
         mcnt0 = 0;
         mcnt1 = 0;
      end else begin
         if (q0.size() != 0 && out0_ready) begin
            void'(q0.pop_front());
            mcnt0 = (mcnt0 + 1) % 65536;
         end
         if (q1.size() != 0 && out1_ready) begin
            void'(q1.pop_front());
            mcnt1 = (mcnt1 + 1) % 65536;
         end
         if (acc && !in_sel) begin
            q0.push_back(in_data);
            last0 = in_data;
         end
         if (acc && in_sel) begin
            q1.push_back(in_data);
            last1 = in_data;
         end
      end
      @(posedge clk);
      #1;
      chk("out0_valid", {31'b0, out0_valid}, {31'b0, q0.size() != 0});
      chk("out1_valid", {31'b0, out1_valid}, {31'b0, q1.size() != 0});
      chk("out0_data", out0_data, last0);
      chk("out1_data", out1_data, last1);
      chk("cnt0", {16'b0, cnt0}, mcnt0[31:0]);
      chk("cnt1", {16'b0, cnt1}, mcnt1[31:0]);
   endtask

   task automatic drive(input logic v, input logic s, input logic [31:0] d);
      in_valid = v;
      in_sel   = s;
      in_data  = d;
   endtask

   initial begin
      int guard;
      rst        = 1'b1;
      out0_ready = 1'b1;
      out1_ready = 1'b1;
      drive(1'b1, 1'b0, 32'hCAFE_0000);
      last0 = '0;
      last1 = '0;
      mcnt0 = 0;
      mcnt1 = 0;
      @(posedge clk);
      #1;

      // Reset held two cycles with a valid beat presented: nothing loads.
      tick();
      drive(1'b1, 1'b1, 32'hCAFE_0001);
      tick();
      chk("reset_cnt0", {16'b0, cnt0}, 32'd0);
      rst = 1'b0;

      // Routing.
      drive(1'b1, 1'b0, 32'hDEAD_BEEF);
      tick();
      chk("route_out0", out0_data, 32'hDEAD_BEEF);
      drive(1'b1, 1'b1, 32'h1234_5678);
      tick();
      chk("route_out1", out1_data, 32'h1234_5678);
      drive(1'b0, 1'b0, 32'h0);
      tick();
      chk("route_cnt0", {16'b0, cnt0}, 32'd1);
      chk("route_cnt1", {16'b0, cnt1}, 32'd1);

      // Back-pressure on channel 0; channel 1 keeps flowing.
      out0_ready = 1'b0;
      drive(1'b1, 1'b0, 32'hA5A5_A5A5);
      tick();
      drive(1'b1, 1'b0, 32'hBBBB_0002);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("bp_hold", out0_data, 32'hA5A5_A5A5);
      end
      drive(1'b1, 1'b1, 32'h0000_0001);
      tick();
      chk("bp_other", out1_data, 32'h0000_0001);
      drive(1'b1, 1'b0, 32'hBBBB_0002);
      out0_ready = 1'b1;
      tick();
      chk("bp_nobubble", {31'b0, out0_valid}, 32'd1);
      chk("bp_queued", out0_data, 32'hBBBB_0002);

      // Full throughput on channel 0.
      for (int i = 1; i <= 8; i++) begin
         drive(1'b1, 1'b0, i);
         tick();
         chk("tput_valid", {31'b0, out0_valid}, 32'd1);
      end
      drive(1'b0, 1'b0, 32'h0);
      tick();

      // Stream channel 1 until its counter reaches 0xFFFF, then one more.
      guard = 0;
      drive(1'b1, 1'b1, 32'h0);
      while (mcnt1 != 65535 && guard < 70000) begin
         in_data = guard;
         tick();
         guard++;
      end
      chk("wrap_reach", {31'b0, guard < 70000}, 32'd1);
      chk("wrap_ffff", {16'b0, cnt1}, 32'h0000_FFFF);
      drive(1'b0, 1'b1, 32'h0);
      tick();
      chk("wrap_zero", {16'b0, cnt1}, 32'h0);
      chk("wrap_cnt0", {16'b0, cnt0}, mcnt0[31:0]);

      // Mid-operation reset with an undrained beat on channel 1.
      out1_ready = 1'b0;
      drive(1'b1, 1'b1, 32'h7777_7777);
      tick();
      drive(1'b0, 1'b1, 32'h0);
      rst = 1'b1;
      tick();
      chk("mid_rst_valid", {31'b0, out1_valid}, 32'd0);
      chk("mid_rst_cnt1", {16'b0, cnt1}, 32'd0);
      rst = 1'b0;
      drive(1'b1, 1'b1, 32'h5555_0001);
      tick();
      chk("post_rst_load", out1_data, 32'h5555_0001);

      // Randomized traffic.
      for (int i = 0; i < 400; i++) begin
         drive(1'($urandom), 1'($urandom), $urandom);
         out0_ready = ($urandom_range(0, 3) != 0);
         out1_ready = ($urandom_range(0, 3) != 0);
         rst        = ($urandom_range(0, 99) == 0);
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
